// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dma_pkg
//  Description : Shared constants and types for the dma_ctrl register-
//                programmed DMA engine (register indices, CTRL/STAT bit
//                positions, transfer FSM state encoding).
//  Revision    : 1.0 - initial release
// ============================================================================
package dma_pkg;

  // Register index carried in adr[3:2]
  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  // CTRL write bit positions
  localparam int CTRL_START    = 0;
  localparam int CTRL_IE       = 1;
  localparam int CTRL_DONE_CLR = 2;
  localparam int CTRL_ABORT    = 3;

  // STAT read bit positions
  localparam int STAT_BUSY = 0;
  localparam int STAT_IE   = 1;
  localparam int STAT_DONE = 2;

  // Transfer FSM: one read, one latency cycle, one write per word
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_LAT  = 2'd2,
    ST_WR   = 2'd3
  } dma_state_e;

endpackage
`default_nettype wire

// File: rtl/dma_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : dma_reg_file
//  Description : IO-window decode for the DMA engine. Holds SRC/DST/LEN and
//                (when DMA_IRQ_EN is defined) the IE bit, produces one-cycle
//                START/DONE_CLR/ABORT command pulses and registered readback.
//  Macro       : DMA_IRQ_EN - implements the IE bit; otherwise IE reads 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_reg_file
  import dma_pkg::*;
#(
  parameter int AWIDTH = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              io_we,
  input  logic [AWIDTH+1:2] io_wadr,
  input  logic [31:0]       io_wdata,
  input  logic [AWIDTH+1:2] io_radr,
  input  logic              busy,
  input  logic              done,
  output logic [31:0]       io_rdata,
  output logic [AWIDTH-1:0] src,
  output logic [AWIDTH-1:0] dst,
  output logic [AWIDTH-1:0] len,
  output logic              ie_nxt,
  output logic              start,
  output logic              done_clr,
  output logic              abort
);

  logic [AWIDTH-1:0] src_q, src_d;
  logic [AWIDTH-1:0] dst_q, dst_d;
  logic [AWIDTH-1:0] len_q, len_d;
  logic              ie_q, ie_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              wsel, rsel;
  logic              unused_wdata;

  // Only the low 16 bytes of the window are mapped
  assign wsel = (io_wadr[AWIDTH+1:4] == '0);
  assign rsel = (io_radr[AWIDTH+1:4] == '0);

  // Not every data bit has a home in every register
  assign unused_wdata = ^io_wdata;

  // Decode IO stores into register updates and command pulses
  always_comb begin
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    ie_d     = ie_q;
    start    = 1'b0;
    done_clr = 1'b0;
    abort    = 1'b0;
    if (io_we && wsel) begin
      case (io_wadr[3:2])
        REG_SRC:  if (!busy) src_d = io_wdata[AWIDTH-1:0];
        REG_DST:  if (!busy) dst_d = io_wdata[AWIDTH-1:0];
        REG_LEN:  if (!busy) len_d = io_wdata[AWIDTH-1:0];
        default: begin
          start    = io_wdata[CTRL_START] & ~busy;
          done_clr = io_wdata[CTRL_DONE_CLR];
          abort    = io_wdata[CTRL_ABORT];
`ifdef DMA_IRQ_EN
          ie_d     = io_wdata[CTRL_IE];
`endif
        end
      endcase
    end
  end

  // Readback mux; sampled into a register so data follows radr by one cycle
  always_comb begin
    rdata_d = '0;
    if (rsel) begin
      case (io_radr[3:2])
        REG_SRC: rdata_d[AWIDTH-1:0] = src_q;
        REG_DST: rdata_d[AWIDTH-1:0] = dst_q;
        REG_LEN: rdata_d[AWIDTH-1:0] = len_q;
        default: begin
          rdata_d[STAT_BUSY] = busy;
          rdata_d[STAT_IE]   = ie_q;
          rdata_d[STAT_DONE] = done;
        end
      endcase
    end
  end

  // Setup registers and readback register
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      rdata_q <= '0;
    end else begin
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef DMA_IRQ_EN
  // Interrupt-enable storage
  always_ff @(posedge clk) begin
    if (rst) ie_q <= 1'b0;
    else     ie_q <= ie_d;
  end
`else
  assign ie_q = 1'b0;
`endif

  assign io_rdata = rdata_q;
  assign src      = src_q;
  assign dst      = dst_q;
  assign len      = len_q;
  // Next-cycle IE lets the interrupt flop track IE and done at the same edge
  assign ie_nxt   = ie_d;

endmodule
`default_nettype wire

// File: rtl/dma_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dma_ctrl
//  Description : Register-programmed DMA engine. Copies LEN words inside the
//                data RAM, moving the low halfword of each source word to the
//                destination word, one access per granted RAM-port cycle.
//  Macro       : DMA_IRQ_EN - enables the completion interrupt (done & IE);
//                otherwise dma_irq is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_ctrl
  import dma_pkg::*;
#(
  parameter int AWIDTH = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dma_io_we,
  input  logic [AWIDTH+1:2] dma_io_wadr,
  input  logic [31:0]       dma_io_wdata,
  input  logic [AWIDTH+1:2] dma_io_radr,
  output logic [31:0]       dma_io_rdata,
  output logic              dma_busy,
  input  logic              dma_gnt,
  output logic              dma_re_ma,
  output logic [AWIDTH+1:2] dataram_radr_ma,
  input  logic [15:0]       dataram_rdata_wb,
  output logic              dma_we_ma,
  output logic [AWIDTH+1:2] dataram_wadr_ma,
  output logic [15:0]       dataram_wdata_ma,
  output logic              dma_irq
);

  dma_state_e        state_q, state_d;
  logic [AWIDTH-1:0] src_cnt_q, src_cnt_d;
  logic [AWIDTH-1:0] dst_cnt_q, dst_cnt_d;
  logic [AWIDTH-1:0] len_cnt_q, len_cnt_d;
  logic [15:0]       hold_q, hold_d;
  logic              done_q, done_d;
  logic              re, we;

  logic [AWIDTH-1:0] src, dst, len;
  logic              ie_nxt, start, done_clr, abort;

  assign dma_busy = (state_q != ST_IDLE);

  dma_reg_file #(
    .AWIDTH (AWIDTH)
  ) u_reg_file (
    .clk      (clk),
    .rst      (rst),
    .io_we    (dma_io_we),
    .io_wadr  (dma_io_wadr),
    .io_wdata (dma_io_wdata),
    .io_radr  (dma_io_radr),
    .busy     (dma_busy),
    .done     (done_q),
    .io_rdata (dma_io_rdata),
    .src      (src),
    .dst      (dst),
    .len      (len),
    .ie_nxt   (ie_nxt),
    .start    (start),
    .done_clr (done_clr),
    .abort    (abort)
  );

  // Transfer FSM next-state, counter updates and RAM strobes
  always_comb begin
    state_d   = state_q;
    src_cnt_d = src_cnt_q;
    dst_cnt_d = dst_cnt_q;
    len_cnt_d = len_cnt_q;
    hold_d    = hold_q;
    done_d    = done_q;
    re        = 1'b0;
    we        = 1'b0;

    // Applied first so a simultaneous START (which reloads done) wins
    if (done_clr) done_d = 1'b0;

    if (abort) begin
      // Abandon the transfer; no strobe, no capture, done untouched
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            src_cnt_d = src;
            dst_cnt_d = dst;
            len_cnt_d = len;
            if (len == '0) begin
              done_d = 1'b1;
            end else begin
              done_d  = 1'b0;
              state_d = ST_RD;
            end
          end
        end
        ST_RD: begin
          if (dma_gnt) begin
            re      = 1'b1;
            state_d = ST_LAT;
          end
        end
        ST_LAT: begin
          hold_d  = dataram_rdata_wb;
          state_d = ST_WR;
        end
        default: begin
          if (dma_gnt) begin
            we        = 1'b1;
            src_cnt_d = src_cnt_q + AWIDTH'(1);
            dst_cnt_d = dst_cnt_q + AWIDTH'(1);
            len_cnt_d = len_cnt_q - AWIDTH'(1);
            if (len_cnt_q == AWIDTH'(1)) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RD;
            end
          end
        end
      endcase
    end
  end

  // FSM state, working counters, hold register and done flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      src_cnt_q <= '0;
      dst_cnt_q <= '0;
      len_cnt_q <= '0;
      hold_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_cnt_q <= src_cnt_d;
      dst_cnt_q <= dst_cnt_d;
      len_cnt_q <= len_cnt_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
    end
  end

  // RAM-side buses are forced to zero whenever their strobe is idle
  assign dma_re_ma        = re;
  assign dataram_radr_ma  = re ? src_cnt_q : '0;
  assign dma_we_ma        = we;
  assign dataram_wadr_ma  = we ? dst_cnt_q : '0;
  assign dataram_wdata_ma = we ? hold_q : '0;

`ifdef DMA_IRQ_EN
  logic irq_q, irq_d;

  assign irq_d = done_d & ie_nxt;

  // Interrupt level follows done & IE from the same edge on
  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= irq_d;
  end

  assign dma_irq = irq_q;
`else
  logic unused_ie;

  assign unused_ie = ie_nxt;
  assign dma_irq   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dma_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dma_ctrl
//  Description : Directed self-checking bench for dma_ctrl with a behavioural
//                data RAM (one-cycle read latency) and strobe logging.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        dma_io_we;
  logic [15:2] dma_io_wadr;
  logic [31:0] dma_io_wdata;
  logic [15:2] dma_io_radr;
  logic [31:0] dma_io_rdata;
  logic        dma_busy;
  logic        dma_gnt;
  logic        dma_re_ma;
  logic [15:2] dataram_radr_ma;
  logic [15:0] dataram_rdata_wb;
  logic        dma_we_ma;
  logic [15:2] dataram_wadr_ma;
  logic [15:0] dataram_wdata_ma;
  logic        dma_irq;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dma_ctrl #(.AWIDTH(14)) dut (
    .clk              (clk),
    .rst              (rst),
    .dma_io_we        (dma_io_we),
    .dma_io_wadr      (dma_io_wadr),
    .dma_io_wdata     (dma_io_wdata),
    .dma_io_radr      (dma_io_radr),
    .dma_io_rdata     (dma_io_rdata),
    .dma_busy         (dma_busy),
    .dma_gnt          (dma_gnt),
    .dma_re_ma        (dma_re_ma),
    .dataram_radr_ma  (dataram_radr_ma),
    .dataram_rdata_wb (dataram_rdata_wb),
    .dma_we_ma        (dma_we_ma),
    .dataram_wadr_ma  (dataram_wadr_ma),
    .dataram_wdata_ma (dataram_wdata_ma),
    .dma_irq          (dma_irq)
  );

  // ---------------- data RAM model and strobe logs ----------------
  logic [15:0] mem     [0:16383];
  logic        written [0:16383];
  logic [13:0] rd_log     [0:63];
  logic [13:0] wr_adr_log [0:63];
  logic [15:0] wr_dat_log [0:63];
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          bad_strobe = 0;
  logic        irq_seen = 1'b0;

  // Unwritten locations hold a per-address pattern: 0xC000 | address
  function automatic logic [15:0] ram_val(input logic [13:0] a);
    if (written[a] === 1'b1) return mem[a];
    return 16'hC000 | {2'b00, a};
  endfunction

  always @(posedge clk) begin
    if (dma_we_ma) begin
      mem[dataram_wadr_ma]     <= dataram_wdata_ma;
      written[dataram_wadr_ma] <= 1'b1;
      wr_adr_log[wr_cnt % 64]  <= dataram_wadr_ma;
      wr_dat_log[wr_cnt % 64]  <= dataram_wdata_ma;
      wr_cnt                   <= wr_cnt + 1;
    end
    if (dma_re_ma) begin
      dataram_rdata_wb     <= ram_val(dataram_radr_ma);
      rd_log[rd_cnt % 64]  <= dataram_radr_ma;
      rd_cnt               <= rd_cnt + 1;
    end
    if ((dma_re_ma || dma_we_ma) && !dma_gnt) bad_strobe <= bad_strobe + 1;
    irq_seen <= irq_seen | dma_irq;
  end

  // ---------------- helpers ----------------
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic io_write(input logic [13:0] adr, input logic [31:0] data);
    @(negedge clk);
    dma_io_we    = 1'b1;
    dma_io_wadr  = adr;
    dma_io_wdata = data;
    @(negedge clk);
    dma_io_we    = 1'b0;
  endtask

  task automatic io_read(input logic [13:0] adr, output logic [31:0] data);
    @(negedge clk);
    dma_io_radr = adr;
    @(negedge clk);
    data = dma_io_rdata;
  endtask

  // Counts negedges until busy drops; bounded
  task automatic wait_idle(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dma_busy && n < 200);
    check_val(tag, {31'b0, dma_busy}, 32'h0);
  endtask

  function automatic logic gnt_pat(input int k);
    return (k % 4 == 0) || (k % 4 == 3);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] v;
    int          n;
    int          rb, wb;

    rst          = 1'b1;
    dma_io_we    = 1'b0;
    dma_io_wadr  = '0;
    dma_io_wdata = '0;
    dma_io_radr  = '0;
    dma_gnt      = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check_val("rst_busy",  {31'b0, dma_busy},  0);
    check_val("rst_re",    {31'b0, dma_re_ma}, 0);
    check_val("rst_we",    {31'b0, dma_we_ma}, 0);
    check_val("rst_irq",   {31'b0, dma_irq},   0);
    check_val("rst_rdata", dma_io_rdata,       0);
    io_read(14'd2, v); check_val("rst_len",  v, 0);
    io_read(14'd3, v); check_val("rst_stat", v, 0);

    // Scenario 1: LEN=4 under continuous grant
    io_write(14'd0, 32'h010);
    io_write(14'd1, 32'h100);
    io_write(14'd2, 32'd4);
    io_read(14'd1, v); check_val("s1_dst_rb", v, 32'h100);
    wb = wr_cnt;
    dma_gnt = 1'b1;
    io_write(14'd3, 32'h1);
    check_val("s1_busy_rise", {31'b0, dma_busy}, 1);
    wait_idle("s1_timeout", n);
    check_val("s1_cycles", n, 12);
    check_val("s1_nwr", wr_cnt - wb, 4);
    for (int i = 0; i < 4; i++) begin
      check_val("s1_wadr", {18'b0, wr_adr_log[(wb + i) % 64]}, 32'h100 + i);
      check_val("s1_wdat", {16'b0, wr_dat_log[(wb + i) % 64]}, 32'hC010 + i);
    end
    io_read(14'd3, v); check_val("s1_stat", v, 32'h4);

    // Scenario 2: same copy to 0x200 with grant pattern 1,0,0,1
    io_write(14'd1, 32'h200);
    wb = wr_cnt;
    io_write(14'd3, 32'h1);
    dma_gnt = gnt_pat(0);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (!dma_busy) break;
      dma_gnt = gnt_pat(n);
    end
    dma_gnt = 1'b1;
    check_val("s2_cycles", n, 16);
    check_val("s2_bad_strobe", bad_strobe, 0);
    check_val("s2_nwr", wr_cnt - wb, 4);
    for (int i = 0; i < 4; i++) begin
      check_val("s2_mem", {16'b0, mem[14'h200 + i]}, {16'b0, mem[14'h100 + i]});
      check_val("s2_wdat", {16'b0, wr_dat_log[(wb + i) % 64]}, 32'hC010 + i);
    end

    // Scenario 3: LEN=0 completes at once without RAM traffic
    io_write(14'd2, 32'd0);
    rb = rd_cnt; wb = wr_cnt;
    io_write(14'd3, 32'h1);
    check_val("s3_busy", {31'b0, dma_busy}, 0);
    io_read(14'd3, v); check_val("s3_stat", v, 32'h4);
    repeat (2) @(negedge clk);
    check_val("s3_nrd", rd_cnt - rb, 0);
    check_val("s3_nwr", wr_cnt - wb, 0);

    // Scenario 4: address wrap
    io_write(14'd0, 32'h3FFF);
    io_write(14'd1, 32'h3FFE);
    io_write(14'd2, 32'd3);
    rb = rd_cnt; wb = wr_cnt;
    io_write(14'd3, 32'h1);
    wait_idle("s4_timeout", n);
    check_val("s4_cycles", n, 9);
    check_val("s4_rd0", {18'b0, rd_log[(rb + 0) % 64]}, 32'h3FFF);
    check_val("s4_rd1", {18'b0, rd_log[(rb + 1) % 64]}, 32'h0000);
    check_val("s4_rd2", {18'b0, rd_log[(rb + 2) % 64]}, 32'h0001);
    check_val("s4_wa0", {18'b0, wr_adr_log[(wb + 0) % 64]}, 32'h3FFE);
    check_val("s4_wa1", {18'b0, wr_adr_log[(wb + 1) % 64]}, 32'h3FFF);
    check_val("s4_wa2", {18'b0, wr_adr_log[(wb + 2) % 64]}, 32'h0000);
    check_val("s4_wd0", {16'b0, wr_dat_log[(wb + 0) % 64]}, 32'hFFFF);
    check_val("s4_wd1", {16'b0, wr_dat_log[(wb + 1) % 64]}, 32'hC000);
    check_val("s4_wd2", {16'b0, wr_dat_log[(wb + 2) % 64]}, 32'hC001);

    // Scenario 5: ABORT after the second write; SRC write while busy ignored
    io_write(14'd0, 32'h020);
    io_write(14'd1, 32'h300);
    io_write(14'd2, 32'd8);
    wb = wr_cnt;
    io_write(14'd3, 32'h1);
    io_write(14'd0, 32'h1234);
    n = 0;
    while ((wr_cnt - wb) < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val("s5_reach2", wr_cnt - wb, 2);
    io_write(14'd3, 32'h8);
    repeat (4) @(negedge clk);
    check_val("s5_busy", {31'b0, dma_busy}, 0);
    check_val("s5_nwr", wr_cnt - wb, 2);
    io_read(14'd3, v); check_val("s5_stat", v, 32'h0);
    io_read(14'd0, v); check_val("s5_src", v, 32'h020);

    // Unmapped address: write ignored, reads zero
    io_write(14'h4, 32'hFFFF_FFFF);
    io_read(14'h4, v); check_val("unmap_rd", v, 32'h0);
    io_read(14'd0, v); check_val("unmap_src", v, 32'h020);

    // Scenario 6: completion interrupt
    io_write(14'd0, 32'h040);
    io_write(14'd1, 32'h340);
    io_write(14'd2, 32'd1);
    io_write(14'd3, 32'h3);
    wait_idle("s6_timeout", n);
    check_val("s6_cycles", n, 3);
    check_val("s6_wdat", {16'b0, mem[14'h340]}, 32'hC040);
`ifdef DMA_IRQ_EN
    check_val("s6_irq_set", {31'b0, dma_irq}, 1);
    io_read(14'd3, v); check_val("s6_stat", v, 32'h6);
    io_write(14'd3, 32'h6);
    check_val("s6_irq_clr", {31'b0, dma_irq}, 0);
    io_read(14'd3, v); check_val("s6_stat_clr", v, 32'h2);
`else
    check_val("s6_irq", {31'b0, dma_irq}, 0);
    io_read(14'd3, v); check_val("s6_stat", v, 32'h4);
    io_write(14'd3, 32'h6);
    io_read(14'd3, v); check_val("s6_stat_clr", v, 32'h0);
    @(negedge clk);
    check_val("s6_irq_never", {31'b0, irq_seen}, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dma_ctrl.md
# dma_ctrl

Register-programmed DMA engine sitting on the far side of the memory-access stage's IO and data-RAM DMA ports. It responds to CPU full-word stores and loads in the `0xC000_xxxx` IO window, which carry the transfer setup and status registers. It initiates word-by-word copies inside the data RAM, moving the low halfword of each source word to the destination word. Each access is issued only while the pipeline stall controller grants the RAM ports.

## Interface
- `AWIDTH`, default 14: word-address and length counter width; matches the `[15:2]` IO/DMA address fields.
- `clk` input, 1 bit: single clock.
- `rst` input, 1 bit: synchronous, active-high reset.
- `dma_io_we` input, 1 bit: CPU full-word store to the IO window.
- `dma_io_wadr` input, [15:2]: IO write word address.
- `dma_io_wdata` input, 32 bits: IO write data.
- `dma_io_radr` input, [15:2]: IO read word address, presented every cycle, no enable.
- `dma_io_rdata` output, 32 bits: registered read data, valid the cycle after `dma_io_radr`.
- `dma_busy` output, 1 bit: transfer in progress; acts as the request to the stall controller.
- `dma_gnt` input, 1 bit: the pipeline has released the data-RAM ports this cycle.
- `dma_re_ma` output, 1 bit: data-RAM read strobe.
- `dataram_radr_ma` output, [15:2]: read word address.
- `dataram_rdata_wb` input, 16 bits: read data, returned one cycle after `dma_re_ma`.
- `dma_we_ma` output, 1 bit: data-RAM write strobe.
- `dataram_wadr_ma` output, [15:2]: write word address.
- `dataram_wdata_ma` output, 16 bits: write data.
- `dma_irq` output, 1 bit: completion interrupt (see Configuration).

## Operation
- Register decode: a register is selected when `adr[15:4]==0`; `adr[3:2]` picks the register.
  - 0 SRC: source word address, AWIDTH bits.
  - 1 DST: destination word address, AWIDTH bits.
  - 2 LEN: word count, AWIDTH bits.
  - 3 CTRL/STAT.
- CTRL/STAT writes: bit0 START, bit1 IE, bit2 DONE_CLR, bit3 ABORT.
- CTRL/STAT reads: bit0 busy, bit1 IE, bit2 done; all other bits 0.
- Unmapped addresses read 0; writes to them are ignored.
- Writes to SRC/DST/LEN while busy are ignored. START while busy is ignored.
- START copies SRC/DST/LEN into the working counters and clears done.
  - If LEN==0, done sets the next cycle and no RAM access occurs.
- FSM states: IDLE, RD, LAT, WR.
  - IDLE → RD on START with LEN≠0.
  - RD: `dma_re_ma=1` and `dataram_radr_ma=src_cnt` only while `dma_gnt` is high; then → LAT. Without grant, stay in RD with `dma_re_ma=0`.
  - LAT: capture `dataram_rdata_wb` into the hold register unconditionally; → WR.
  - WR: `dma_we_ma=1`, `dataram_wadr_ma=dst_cnt`, `dataram_wdata_ma=hold` only while `dma_gnt` is high. On the write, increment src_cnt and dst_cnt, decrement len_cnt, then → RD, or → IDLE with done=1 if len_cnt was 1.
- Counters wrap modulo 2^AWIDTH.
- ABORT in any state → IDLE the next cycle. done is not set, and an in-flight LAT capture is discarded.
- DONE_CLR clears done. START and DONE_CLR written together: START wins, so done=0.
- Unused address bits on the RAM outputs are 0 when their strobe is low.
- Reset values:
  - All outputs are 0.
  - SRC, DST, LEN, IE, done and all counters are 0.
  - FSM is in IDLE.

## Timing
- IO write takes effect at the next clock edge. IO read: `dma_io_rdata` is registered from `dma_io_radr`, one-cycle latency, no read side effects.
- `dma_busy` rises the cycle after a START store and falls the same cycle done sets.
- Throughput is 3 cycles per word under continuous grant. Total time is 3·LEN cycles from the first RD to done.
- Strobes are combinational from state and `dma_gnt`. All other outputs are registered.
- `rst` mid-transfer returns everything to reset values at that edge. No partial write is issued after it.

## Configuration
- `DMA_IRQ_EN` defined:
  - IE is implemented.
  - `dma_irq` is a registered level equal to done & IE, cleared by DONE_CLR.
- `DMA_IRQ_EN` undefined:
  - IE is not stored and reads 0.
  - `dma_irq` is tied to 0.

## Structure
- Package `dma_pkg`:
  - Register index constants (SRC=0, DST=1, LEN=2, CTRL=3).
  - CTRL bit positions.
  - FSM state enum (IDLE, RD, LAT, WR).
- Sub-module `dma_reg_file` holds the IO decode, SRC/DST/LEN/IE storage and registered readback.
- The FSM, counters and hold register live in `dma_ctrl`.

## Test plan
- SRC=0x010, DST=0x100, LEN=4, START, gnt held at 1 → four writes at 0x100..0x103 with the source low halfwords; done=1 and busy=0 after 12 cycles; STAT reads 0x4.
- Same setup with `dma_gnt` toggling 1,0,0,1 → no strobe while gnt=0; data in RAM is identical to the first scenario; completion is delayed by exactly the number of ungranted RD/WR cycles.
- LEN=0, START → busy stays 0, done=1 one cycle later, no `dma_re_ma`/`dma_we_ma` pulse.
- SRC=0x3FFF, DST=0x3FFE, LEN=3 → reads 0x3FFF, 0x0000, 0x0001; writes 0x3FFE, 0x3FFF, 0x0000.
- LEN=8, ABORT after the 2nd write → FSM returns to IDLE; exactly 2 writes occur; done=0; a write to SRC during the transfer was ignored (SRC reads back its original value).
- With `DMA_IRQ_EN`: IE=1, LEN=1 transfer → `dma_irq`=1 after done; DONE_CLR → `dma_irq`=0 the next cycle. Without the macro, `dma_irq` stays 0 throughout.
